col_psum_fifo: RTL and testbench

COL_PSUM_FIFO -- requirements
Module: col_psum_fifo

---
 rtl/col_psum_fifo_pkg.sv | 13 +
 rtl/psum_col_fifo.sv | 87 ++++++++
 rtl/col_psum_fifo.sv | 59 +++++
 tb/tb_col_psum_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/col_psum_fifo_pkg.sv
// Shared defaults and helpers for the column partial-sum FIFO bank.
package col_psum_fifo_pkg;

    localparam int COL_DEFAULT     = 8;
    localparam int PSUM_BW_DEFAULT = 16;
    localparam int DEPTH_DEFAULT   = 64;

    // Pointers and occupancy carry one extra bit so a full FIFO (occ == depth) is representable.
    function automatic int ptrWidth(input int depthVal);
        return $clog2(depthVal) + 1;
    endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Single-column first-word-fall-through FIFO used once per array column.
// Optional occupancy/overflow status ports appear when COL_PSUM_FIFO_STATUS_EN is defined.
module psum_col_fifo
    import col_psum_fifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEFAULT,
    parameter int depth   = DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_wr,
    input  logic                          i_pop,
    input  logic [psum_bw-1:0]            i_data,
    output logic [psum_bw-1:0]            o_data,
    output logic                          o_empty,
    output logic                          o_full
`ifdef COL_PSUM_FIFO_STATUS_EN
    ,
    output logic [ptrWidth(depth)-1:0]    o_occ,
    output logic                          o_ovf
`endif
);

    localparam int PW = ptrWidth(depth);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] OCC_FULL = PW'(depth);

    logic [psum_bw-1:0] r_mem [depth];
    logic [PW-1:0]      r_wrPtr;
    logic [PW-1:0]      r_rdPtr;
    logic [PW-1:0]      r_occ;
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_occ == '0);
    assign o_full  = (r_occ == OCC_FULL);

    // A write into a full column is dropped outright, even if a pop frees a slot this cycle.
    assign w_push = i_wr & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    assign o_data = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + PTR_ONE;
                2'b01:   r_occ <= r_occ - PTR_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef COL_PSUM_FIFO_STATUS_EN
    logic r_ovf;

    // Sticky flag: remembers any dropped write until the next reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (i_wr && o_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_occ = r_occ;
    assign o_ovf = r_ovf;
`endif

endmodule

// File: rtl/col_psum_fifo.sv
// Bank of per-column psum FIFOs that realigns skewed MAC-row outputs into whole rows.
// Define COL_PSUM_FIFO_STATUS_EN to expose per-column occupancy (o_occ) and sticky overflow (o_ovf).
module col_psum_fifo
    import col_psum_fifo_pkg::*;
#(
    parameter int col     = COL_DEFAULT,
    parameter int psum_bw = PSUM_BW_DEFAULT,
    parameter int depth   = DEPTH_DEFAULT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [col-1:0]                    wr,
    input  logic [psum_bw*col-1:0]            in,
    input  logic                              rd,
    output logic [psum_bw*col-1:0]            out,
    output logic                              o_valid,
    output logic                              o_full,
    output logic                              o_ready
`ifdef COL_PSUM_FIFO_STATUS_EN
    ,
    output logic [col*ptrWidth(depth)-1:0]    o_occ,
    output logic [col-1:0]                    o_ovf
`endif
);

    localparam int PW = ptrWidth(depth);

    logic [col-1:0] w_empty;
    logic [col-1:0] w_full;
    logic           w_pop;

    // A row pops only when every column has an entry, so all read pointers move in lockstep.
    assign w_pop   = rd & o_valid;
    assign o_valid = ~(|w_empty);
    assign o_full  = |w_full;
    assign o_ready = ~o_full;

    for (genvar i = 0; i < col; i++) begin : genCol
        psum_col_fifo #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_colFifo (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (wr[i]),
            .i_pop   (w_pop),
            .i_data  (in[psum_bw*i +: psum_bw]),
            .o_data  (out[psum_bw*i +: psum_bw]),
            .o_empty (w_empty[i]),
            .o_full  (w_full[i])
`ifdef COL_PSUM_FIFO_STATUS_EN
            ,
            .o_occ   (o_occ[PW*i +: PW]),
            .o_ovf   (o_ovf[i])
`endif
        );
    end

endmodule

// File: tb/tb_col_psum_fifo.sv
// Directed + randomized bench for col_psum_fifo against a per-column queue model.
// Status ports are checked too when COL_PSUM_FIFO_STATUS_EN is defined.
module tb_col_psum_fifo;
    import col_psum_fifo_pkg::*;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 64;
    localparam int PW      = ptrWidth(DEPTH);
    localparam int BUS_W   = PSUM_BW * COL;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [COL-1:0]     wr = '0;
    logic [BUS_W-1:0]   inBus = '0;
    logic               rd = 1'b0;
    logic [BUS_W-1:0]   outBus;
    logic               oValid;
    logic               oFull;
    logic               oReady;
`ifdef COL_PSUM_FIFO_STATUS_EN
    logic [COL*PW-1:0]  oOcc;
    logic [COL-1:0]     oOvf;
`endif

    int checks = 0;
    int errors = 0;

    logic [PSUM_BW-1:0] modelQ [COL][$];
    logic [COL-1:0]     modelOvf = '0;

    col_psum_fifo #(
        .col     (COL),
        .psum_bw (PSUM_BW),
        .depth   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .in      (inBus),
        .rd      (rd),
        .out     (outBus),
        .o_valid (oValid),
        .o_full  (oFull),
        .o_ready (oReady)
`ifdef COL_PSUM_FIFO_STATUS_EN
        ,
        .o_occ   (oOcc),
        .o_ovf   (oOvf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit modelValid();
        for (int i = 0; i < COL; i++) begin
            if (modelQ[i].size() == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit modelFull();
        for (int i = 0; i < COL; i++) begin
            if (modelQ[i].size() == DEPTH) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [BUS_W-1:0] randRow();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkVal(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string step);
        logic [BUS_W-1:0] expOut;
        logic             expValid;
        expValid = modelValid();
        checkVal({step, " o_valid"}, BUS_W'(oValid), BUS_W'(expValid));
        checkVal({step, " o_full"},  BUS_W'(oFull),  BUS_W'(modelFull()));
        checkVal({step, " o_ready"}, BUS_W'(oReady), BUS_W'(!modelFull()));
        if (expValid) begin
            expOut = '0;
            for (int i = 0; i < COL; i++) expOut[PSUM_BW*i +: PSUM_BW] = modelQ[i][0];
            checkVal({step, " out"}, outBus, expOut);
        end
`ifdef COL_PSUM_FIFO_STATUS_EN
        begin
            logic [COL*PW-1:0] expOcc;
            for (int i = 0; i < COL; i++) expOcc[PW*i +: PW] = PW'(modelQ[i].size());
            checkVal({step, " o_occ"}, BUS_W'(oOcc), BUS_W'(expOcc));
            checkVal({step, " o_ovf"}, BUS_W'(oOvf), BUS_W'(modelOvf));
        end
`endif
    endtask

    // Drive one cycle, advance the model at the edge, then compare on the falling edge.
    task automatic applyStimulus(input logic rstN, input logic [COL-1:0] w,
                                 input logic [BUS_W-1:0] d, input logic r, input string step);
        logic             valid;
        logic [COL-1:0]   fullPre;
        reset = rstN;
        wr    = w;
        inBus = d;
        rd    = r;
        @(posedge clk);
        if (!rstN) begin
            for (int i = 0; i < COL; i++) modelQ[i].delete();
            modelOvf = '0;
        end else begin
            valid = modelValid();
            for (int i = 0; i < COL; i++) fullPre[i] = (modelQ[i].size() == DEPTH);
            for (int i = 0; i < COL; i++) begin
                if (r && valid) void'(modelQ[i].pop_front());
                if (w[i]) begin
                    if (!fullPre[i]) modelQ[i].push_back(d[PSUM_BW*i +: PSUM_BW]);
                    else modelOvf[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        checkOutput(step);
    endtask

    task automatic drain(input string step);
        int n;
        for (n = 0; n < 4 * DEPTH && modelValid(); n++) begin
            applyStimulus(1'b1, '0, '0, 1'b1, step);
        end
        checkVal({step, " drained"}, BUS_W'(oValid), '0);
    endtask

    initial begin
        logic [BUS_W-1:0] row;
        int rowsWritten;
        logic [COL-1:0] w;
        logic r;

        // Reset state
        applyStimulus(1'b0, '0, '0, 1'b0, "reset0");
        applyStimulus(1'b0, '0, '0, 1'b0, "reset1");
        checkVal("reset o_ready", BUS_W'(oReady), BUS_W'(1'b1));

        // Single aligned row with columns 1..8
        for (int i = 0; i < COL; i++) row[PSUM_BW*i +: PSUM_BW] = PSUM_BW'(i + 1);
        applyStimulus(1'b1, '1, row, 1'b0, "row18");
        checkVal("row18 literal out", outBus, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        applyStimulus(1'b1, '0, '0, 1'b1, "row18 pop");
        checkVal("row18 popped", BUS_W'(oValid), '0);

        // Skewed column writes assemble into one row
        for (int i = 0; i < COL; i++) begin
            applyStimulus(1'b1, COL'(1) << i, randRow(), 1'b0, $sformatf("skew%0d", i));
        end
        checkVal("skew aligned", BUS_W'(oValid), BUS_W'(1'b1));
        applyStimulus(1'b1, '0, '0, 1'b1, "skew pop");

        // Partial row: rd must not pop
        applyStimulus(1'b1, 8'h7F, randRow(), 1'b0, "partial wr");
        applyStimulus(1'b1, '0, '0, 1'b1, "partial rd");
        applyStimulus(1'b1, '0, '0, 1'b1, "partial rd2");
        applyStimulus(1'b1, 8'h80, randRow(), 1'b0, "partial col7");
        applyStimulus(1'b1, '0, '0, 1'b1, "partial pop");

        // Fill to full, overflow, write+pop at full, drain
        applyStimulus(1'b0, '0, '0, 1'b0, "fill reset");
        for (int n = 0; n < DEPTH; n++) applyStimulus(1'b1, '1, randRow(), 1'b0, "fill");
        checkVal("fill o_full", BUS_W'(oFull), BUS_W'(1'b1));
        checkVal("fill o_ready", BUS_W'(oReady), '0);
        applyStimulus(1'b1, '1, randRow(), 1'b0, "overflow");
`ifdef COL_PSUM_FIFO_STATUS_EN
        checkVal("overflow o_ovf", BUS_W'(oOvf), BUS_W'(8'hFF));
`endif
        applyStimulus(1'b1, '1, randRow(), 1'b1, "full wr+rd");
        drain("fill drain");

        // Random interleaving across pointer wrap
        applyStimulus(1'b0, '0, '0, 1'b0, "wrap reset");
        rowsWritten = 0;
        for (int n = 0; n < 4000 && rowsWritten < 100; n++) begin
            w = ($urandom % 3 != 0) ? '1 : '0;
            r = 1'($urandom % 2);
            if (w != 0 && modelQ[0].size() < DEPTH) rowsWritten++;
            applyStimulus(1'b1, w, randRow(), r, "wrap");
        end
        checkVal("wrap rows", BUS_W'(rowsWritten), BUS_W'(100));
        drain("wrap drain");

        // Random per-column masks
        for (int n = 0; n < 200; n++) begin
            applyStimulus(1'b1, COL'($urandom), randRow(), 1'($urandom % 2), "mask");
        end
        drain("mask drain");

        // Reset mid-operation discards rows and ignores wr/rd
        applyStimulus(1'b0, '0, '0, 1'b0, "mid reset0");
        for (int n = 0; n < 3; n++) applyStimulus(1'b1, '1, randRow(), 1'b0, "mid fill");
        applyStimulus(1'b0, '1, randRow(), 1'b1, "mid reset");
        checkVal("mid reset o_valid", BUS_W'(oValid), '0);
        applyStimulus(1'b1, '0, '0, 1'b1, "mid rd ignored");
        applyStimulus(1'b1, '1, randRow(), 1'b0, "mid new row");
        applyStimulus(1'b1, '0, '0, 1'b1, "mid pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
